sfr_unit: RTL and testbench



---
 rtl/sfr_pkg.sv | 49 ++++
 rtl/sfr_timer.sv | 100 ++++++++++
 rtl/sfr_unit.sv | 101 ++++++++++
 tb/tb_sfr_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sfr_pkg.sv
// sfr_pkg: shared definitions for the CPU special-function-register unit.
//   - version identification macros (overridable from the command line)
//   - SFR address map, FEAT1 capability masks, TCTRL bit positions
`ifndef VER_MAIN
`define VER_MAIN 8'd1
`endif
`ifndef VER_SUB
`define VER_SUB 8'd2
`endif
`ifndef VER_REL
`define VER_REL 8'd3
`endif

package sfr_pkg;

  localparam logic [7:0]  VER_MAIN_V   = `VER_MAIN;
  localparam logic [7:0]  VER_SUB_V    = `VER_SUB;
  localparam logic [7:0]  VER_REL_V    = `VER_REL;
  localparam logic [31:0] VERSION_WORD = {8'd0, VER_MAIN_V, VER_SUB_V, VER_REL_V};

  // Address map
  localparam int SFR_VERSION  = 1;
  localparam int SFR_FEAT1    = 2;
  localparam int SFR_FEAT2    = 3;
  localparam int SFR_CYC_LO   = 4;
  localparam int SFR_CYC_HI   = 5;
  localparam int SFR_TCTRL    = 6;
  localparam int SFR_TRELOAD  = 7;
  localparam int SFR_TCOUNT   = 8;
  localparam int SFR_SCRATCH0 = 9;

  // FEAT1 capability bits
  localparam logic [31:0] FEAT1_GETB_EXT = 32'h0000_0001;
  localparam logic [31:0] FEAT1_SFR      = 32'h0000_0002;
  localparam logic [31:0] FEAT1_FLAG32   = 32'h0000_0004;
  localparam logic [31:0] FEAT1_CES      = 32'h0000_0008;
  localparam logic [31:0] FEAT1_TIMER    = 32'h0000_0010;
  localparam logic [31:0] FEAT1_CYCLE    = 32'h0000_0020;
  localparam logic [31:0] FEAT1_WORD     = FEAT1_GETB_EXT | FEAT1_SFR | FEAT1_FLAG32 |
                                           FEAT1_CES | FEAT1_TIMER | FEAT1_CYCLE;

  // TCTRL layout
  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_AUTO = 1;
  localparam int TCTRL_IE   = 2;
  localparam int TCTRL_FLAG = 3;
  localparam int TCTRL_W    = 4;

endpackage

// File: rtl/sfr_timer.sv
// sfr_timer: programmable down-count timer with level interrupt.
//   clk, reset      : clock, synchronous active-high reset
//   ctrl_we         : write strobe for TCTRL (EN/AUTO/IE, bit 3 = W1C FLAG)
//   reload_we       : write strobe for TRELOAD
//   count_we        : write strobe for TCOUNT
//   wdata           : write data shared by all three strobes
//   ctrl            : {FLAG, IE, AUTO, EN}
//   reload, count   : current TRELOAD / TCOUNT
//   irq             : FLAG & IE, straight from flops
module sfr_timer
  import sfr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ctrl_we,
  input  logic               reload_we,
  input  logic               count_we,
  input  logic [WIDTH-1:0]   wdata,
  output logic [TCTRL_W-1:0] ctrl,
  output logic [WIDTH-1:0]   reload,
  output logic [WIDTH-1:0]   count,
  output logic               irq
);

  logic             en_q, en_d;
  logic             auto_q, auto_d;
  logic             ie_q, ie_d;
  logic             flag_q, flag_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             expire;

  assign expire = en_q && (count_q == '0);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    en_d     = en_q;
    auto_d   = auto_q;
    ie_d     = ie_q;
    flag_d   = flag_q;
    reload_d = reload_q;
    count_d  = count_q;

    // Hardware timer step, overridden below by any CPU write to the same field.
    if (en_q) begin
      if (expire) begin
        if (auto_q) count_d = reload_q;
        else        en_d    = 1'b0;
      end else begin
        count_d = count_q - 1'b1;
      end
    end

    if (reload_we) reload_d = wdata;
    if (count_we)  count_d  = wdata;
    if (ctrl_we) begin
      en_d   = wdata[TCTRL_EN];
      auto_d = wdata[TCTRL_AUTO];
      ie_d   = wdata[TCTRL_IE];
      if (wdata[TCTRL_FLAG]) flag_d = 1'b0;
    end

    // Set after the W1C so a simultaneous expiry keeps FLAG high.
    if (expire) flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
    if (reset) begin
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      ie_q     <= 1'b0;
      flag_q   <= 1'b0;
      reload_q <= '0;
      count_q  <= '0;
    end else begin
      en_q     <= en_d;
      auto_q   <= auto_d;
      ie_q     <= ie_d;
      flag_q   <= flag_d;
      reload_q <= reload_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    ctrl             = '0;
    ctrl[TCTRL_EN]   = en_q;
    ctrl[TCTRL_AUTO] = auto_q;
    ctrl[TCTRL_IE]   = ie_q;
    ctrl[TCTRL_FLAG] = flag_q;
  end

  assign reload = reload_q;
  assign count  = count_q;
  assign irq    = flag_q & ie_q;

endmodule

// File: rtl/sfr_unit.sv
// sfr_unit: CPU special-function-register block.
//   Identification (VERSION/FEAT1/FEAT2), 2*WIDTH-bit cycle counter with
//   high-half snapshot on CYC_LO read, one down-count timer, scratch registers.
//   clk, reset : clock, synchronous active-high reset
//   addr       : register address
//   cen        : access strobe, qualifies every side effect
//   wen        : write enable (with cen)
//   din        : write data
//   dout       : combinational read data for addr
//   irq        : timer interrupt
module sfr_unit
  import sfr_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 4,
  parameter int NUM_SCRATCH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cen,
  input  logic              wen,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              irq
);

  // Keeps the array legal when no scratch registers are configured.
  localparam int SCR_N = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

  int                    addr_i;
  logic                  wr;
  logic [2*WIDTH-1:0]    cyc_q, cyc_d;
  logic [WIDTH-1:0]      snap_q, snap_d;
  logic [WIDTH-1:0]      scratch_q [SCR_N];
  logic [WIDTH-1:0]      scratch_d [SCR_N];
  logic [TCTRL_W-1:0]    t_ctrl;
  logic [WIDTH-1:0]      t_reload;
  logic [WIDTH-1:0]      t_count;

  assign addr_i = int'(addr);
  assign wr     = cen & wen;

  sfr_timer #(.WIDTH(WIDTH)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .ctrl_we   (wr && (addr_i == SFR_TCTRL)),
    .reload_we (wr && (addr_i == SFR_TRELOAD)),
    .count_we  (wr && (addr_i == SFR_TCOUNT)),
    .wdata     (din),
    .ctrl      (t_ctrl),
    .reload    (t_reload),
    .count     (t_count),
    .irq       (irq)
  );

  always_comb begin
    cyc_d  = cyc_q + 1'b1;
    snap_d = snap_q;
    // A CYC_LO read freezes the matching high half so software gets a coherent pair.
    if (cen && !wen && (addr_i == SFR_CYC_LO)) snap_d = cyc_q[2*WIDTH-1:WIDTH];

    scratch_d = scratch_q;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (wr && (addr_i == SFR_SCRATCH0 + i)) scratch_d[i] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q     <= '0;
      snap_q    <= '0;
      // NOTE: scratch is a handful of flops, not a RAM, so clearing it on reset is cheap and defined.
      scratch_q <= '{default: '0};
    end else begin
      cyc_q     <= cyc_d;
      snap_q    <= snap_d;
      scratch_q <= scratch_d;
    end
  end

  always_comb begin
    dout = '0;
    case (addr_i)
      SFR_VERSION: dout = WIDTH'(VERSION_WORD);
      SFR_FEAT1:   dout = WIDTH'(FEAT1_WORD);
      SFR_FEAT2:   dout = WIDTH'(8'(NUM_SCRATCH));
      SFR_CYC_LO:  dout = cyc_q[WIDTH-1:0];
      SFR_CYC_HI:  dout = snap_q;
      SFR_TCTRL:   dout = WIDTH'(t_ctrl);
      SFR_TRELOAD: dout = t_reload;
      SFR_TCOUNT:  dout = t_count;
      default: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (addr_i == SFR_SCRATCH0 + i) dout = scratch_q[i];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_sfr_unit.sv
// tb_sfr_unit: directed self-checking bench for sfr_unit.
//   dut   : WIDTH=32, NUM_SCRATCH=2 (map, scratch, timer, reset)
//   dut_s : WIDTH=16, NUM_SCRATCH=0 (cycle counter wrap and snapshot)
`timescale 1ns/1ps
module tb_sfr_unit;

  logic        clk = 1'b0;
  always #50 clk = ~clk;

  logic        reset;
  logic [3:0]  addr;
  logic        cen, wen;
  logic [31:0] din, dout;
  logic        irq;

  logic        reset_s;
  logic [3:0]  addr_s;
  logic        cen_s, wen_s;
  logic [15:0] din_s, dout_s;
  logic        irq_s;

  int total = 0;
  int bad   = 0;

  sfr_unit #(.WIDTH(32), .ADDR_W(4), .NUM_SCRATCH(2)) dut (
    .clk(clk), .reset(reset), .addr(addr), .cen(cen), .wen(wen),
    .din(din), .dout(dout), .irq(irq)
  );

  sfr_unit #(.WIDTH(16), .ADDR_W(4), .NUM_SCRATCH(0)) dut_s (
    .clk(clk), .reset(reset_s), .addr(addr_s), .cen(cen_s), .wen(wen_s),
    .din(din_s), .dout(dout_s), .irq(irq_s)
  );

  // Inputs change 1ns after the rising edge; reads sample a few ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    addr = 4'(a); din = d; cen = 1'b1; wen = 1'b1;
    step();
    cen = 1'b0; wen = 1'b0;
  endtask

  task automatic peek(input int a, output logic [31:0] v);
    addr = 4'(a);
    #1;
    v = dout;
  endtask

  task automatic test_reset();
    int          a_tab [9] = '{0, 1, 2, 3, 5, 6, 7, 8, 9};
    logic [31:0] e_tab [9] = '{32'h0, 32'h0001_0203, 32'h0000_003F, 32'h0000_0002,
                               32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] v;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      peek(a_tab[i], v);
      total++;
      if (v !== e_tab[i]) begin
        bad++;
        $display("FAIL reset_read addr=%0d: got %h want %h", a_tab[i], v, e_tab[i]);
      end
    end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_scratch();
    logic [31:0] v;
    wr(9, 32'hDEAD_BEEF);
    wr(10, 32'h1234_5678);
    wr(2, 32'h0000_0000);
    wr(5, 32'hFFFF_FFFF);
    wr(15, 32'hA5A5_A5A5);
    peek(9, v);
    total++; if (v !== 32'hDEAD_BEEF) begin bad++; $display("FAIL scratch0: got %h want %h", v, 32'hDEAD_BEEF); end
    peek(10, v);
    total++; if (v !== 32'h1234_5678) begin bad++; $display("FAIL scratch1: got %h want %h", v, 32'h1234_5678); end
    peek(2, v);
    total++; if (v !== 32'h0000_003F) begin bad++; $display("FAIL feat1_ro: got %h want %h", v, 32'h3F); end
    peek(5, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL cyc_hi_ro: got %h want 0", v); end
    peek(15, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL unmapped: got %h want 0", v); end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    wr(8, 32'd3);
    wr(6, 32'h5);
    for (int k = 1; k <= 3; k++) begin
      step();
      peek(8, v);
      total++; if (v !== 32'(3 - k)) begin bad++; $display("FAIL oneshot_count k=%0d: got %h want %h", k, v, 32'(3 - k)); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_early_irq k=%0d: got %b want 0", k, irq); end
    end
    peek(6, v);
    total++; if (v !== 32'h5) begin bad++; $display("FAIL oneshot_ctrl_pre: got %h want 5", v); end
    step();
    peek(6, v);
    total++; if (v !== 32'hC) begin bad++; $display("FAIL oneshot_flag: got %h want c", v); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL oneshot_irq: got %b want 1", irq); end
    step();
    step();
    peek(8, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL oneshot_hold_count: got %h want 0", v); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL oneshot_irq_hold: got %b want 1", irq); end
    wr(6, 32'h8);
    peek(6, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL w1c_ctrl: got %h want 0", v); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq: got %b want 0", irq); end
  endtask

  task automatic test_auto();
    logic [31:0] v, c;
    wr(7, 32'd2);
    wr(8, 32'd0);
    wr(6, 32'h3);                        // running, count 0
    step();                              // expiry: flag, reload
    peek(6, v); peek(8, c);
    total++; if (v !== 32'hB || c !== 32'd2) begin bad++; $display("FAIL auto_first: ctrl=%h count=%h want b/2", v, c); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL auto_ie_gate: got %b want 0", irq); end
    wr(6, 32'hB);                        // plain W1C
    peek(6, v); peek(8, c);
    total++; if (v !== 32'h3 || c !== 32'd1) begin bad++; $display("FAIL auto_w1c: ctrl=%h count=%h want 3/1", v, c); end
    step();
    peek(6, v); peek(8, c);
    total++; if (v !== 32'h3 || c !== 32'd0) begin bad++; $display("FAIL auto_zero: ctrl=%h count=%h want 3/0", v, c); end
    wr(6, 32'hB);                        // W1C on the reload edge
    peek(6, v); peek(8, c);
    total++; if (v !== 32'hB || c !== 32'd2) begin bad++; $display("FAIL auto_set_wins: ctrl=%h count=%h want b/2", v, c); end
    wr(6, 32'hB);
    step();
    step();                              // third edge after the previous set
    peek(6, v); peek(8, c);
    total++; if (v !== 32'hB || c !== 32'd2) begin bad++; $display("FAIL auto_period: ctrl=%h count=%h want b/2", v, c); end
    wr(8, 32'd7);                        // CPU write beats decrement
    peek(8, c); peek(7, v);
    total++; if (c !== 32'd7) begin bad++; $display("FAIL count_write_wins: got %h want 7", c); end
    total++; if (v !== 32'd2) begin bad++; $display("FAIL reload_read: got %h want 2", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    wr(8, 32'd5);
    wr(6, 32'hF);                        // EN|AUTO|IE, clear FLAG, count 5->4
    peek(6, v);
    total++; if (v !== 32'h7) begin bad++; $display("FAIL mid_ctrl: got %h want 7", v); end
    reset = 1'b1;
    step();
    for (int a = 6; a <= 10; a++) begin
      peek(a, v);
      total++; if (v !== 32'h0) begin bad++; $display("FAIL mid_reset addr=%0d: got %h want 0", a, v); end
    end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_reset_irq: got %b want 0", irq); end
    reset = 1'b0;
    repeat (8) step();
    peek(6, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL post_reset_ctrl: got %h want 0", v); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL post_reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_cycle();
    reset_s = 1'b1;
    step();
    reset_s = 1'b0;                      // counter is 0 during this cycle
    addr_s = 4'd4;
    #1;
    total++; if (dout_s !== 16'h0) begin bad++; $display("FAIL cyc_start: got %h want 0", dout_s); end
    repeat (16'hFFFF) step();            // counter now 0x0000_FFFF
    cen_s = 1'b1;
    #1;
    total++; if (dout_s !== 16'hFFFF) begin bad++; $display("FAIL cyc_lo_max: got %h want ffff", dout_s); end
    step();                              // snapshot latched 0, counter 0x1_0000
    cen_s = 1'b0;
    addr_s = 4'd5;
    #1;
    total++; if (dout_s !== 16'h0) begin bad++; $display("FAIL cyc_snap0: got %h want 0", dout_s); end
    addr_s = 4'd4;
    #1;
    total++; if (dout_s !== 16'h0) begin bad++; $display("FAIL cyc_lo_wrap: got %h want 0", dout_s); end
    cen_s = 1'b1;
    step();                              // snapshot latched 1
    cen_s = 1'b0;
    addr_s = 4'd5;
    #1;
    total++; if (dout_s !== 16'h1) begin bad++; $display("FAIL cyc_snap1: got %h want 1", dout_s); end
    total++; if (irq_s !== 1'b0) begin bad++; $display("FAIL small_irq: got %b want 0", irq_s); end
  endtask

  initial begin
    reset = 1'b1; addr = '0; cen = 1'b0; wen = 1'b0; din = '0;
    reset_s = 1'b1; addr_s = '0; cen_s = 1'b0; wen_s = 1'b0; din_s = '0;
    test_reset();
    test_scratch();
    test_oneshot();
    test_auto();
    test_reset_mid();
    test_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
